suma_sat_acc: RTL and testbench

SUMA_SAT_ACC -- requirements
Module: suma_sat_acc

---
 rtl/suma_sat_acc_if.sv | 29 ++
 rtl/suma_sat_acc.sv | 105 ++++++++++
 tb/tb_suma_sat_acc.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/suma_sat_acc_if.sv
// Handshake and data bundle for the saturating add/sub/accumulate unit.
// The master side drives operands and out_ready; the slave side returns results and flags.
interface suma_sat_acc_if #(
   parameter int N  = 25,
   parameter int CW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  A;
   logic [N-1:0]  B;
   logic [1:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  SUMA;
   logic          sat_hi;
   logic          sat_lo;
   logic          sat_sticky;
   logic [CW-1:0] sat_cnt;

   modport master (
      output in_valid, A, B, op, out_ready,
      input  in_ready, out_valid, SUMA, sat_hi, sat_lo, sat_sticky, sat_cnt
   );

   modport slave (
      input  in_valid, A, B, op, out_ready,
      output in_ready, out_valid, SUMA, sat_hi, sat_lo, sat_sticky, sat_cnt
   );
endinterface

// File: rtl/suma_sat_acc.sv
// Signed add/sub/accumulate with symmetric saturation, one-cycle latency,
// a single-entry valid/ready output register and saturation statistics.
module suma_sat_acc #(
   parameter int N  = 25,
   parameter int CW = 8
) (
   input  logic           clk,
   input  logic           reset,
   suma_sat_acc_if.slave  bus
);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   // Symmetric limits: -2^(N-1) is never produced, it clamps to MIN.
   localparam logic signed [N:0] MAX_E = {2'b00, {(N-1){1'b1}}};
   localparam logic signed [N:0] MIN_E = -MAX_E;

   logic [N-1:0]      acc_reg;
   logic [N-1:0]      suma_reg;
   logic              out_valid_reg;
   logic              sat_hi_reg;
   logic              sat_lo_reg;
   logic              sat_sticky_reg;
   logic [CW-1:0]     sat_cnt_reg;

   logic signed [N:0] a_ext;
   logic signed [N:0] b_ext;
   logic signed [N:0] acc_ext;
   logic signed [N:0] raw_next;
   logic [N-1:0]      res_next;
   logic              hi_next;
   logic              lo_next;
   logic              xfer;

   assign a_ext   = {bus.A[N-1], bus.A};
   assign b_ext   = {bus.B[N-1], bus.B};
   assign acc_ext = {acc_reg[N-1], acc_reg};

   assign bus.in_ready = !out_valid_reg || bus.out_ready;
   assign xfer         = bus.in_valid && bus.in_ready;

   // N+1 bits holds every sum/difference of two N-bit signed values exactly.
   always_comb begin
      raw_next = '0;
      case (bus.op)
         OP_ADD:  raw_next = a_ext + b_ext;
         OP_SUB:  raw_next = a_ext - b_ext;
         OP_ACC:  raw_next = acc_ext + a_ext;
         default: raw_next = '0;
      endcase
      hi_next = (raw_next > MAX_E);
      lo_next = (raw_next < MIN_E);
      if (hi_next) begin
         res_next = MAX_E[N-1:0];
      end else if (lo_next) begin
         res_next = MIN_E[N-1:0];
      end else begin
         res_next = raw_next[N-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg        <= '0;
         suma_reg       <= '0;
         out_valid_reg  <= 1'b0;
         sat_hi_reg     <= 1'b0;
         sat_lo_reg     <= 1'b0;
         sat_sticky_reg <= 1'b0;
         sat_cnt_reg    <= '0;
      end else if (xfer) begin
         out_valid_reg <= 1'b1;
         suma_reg      <= res_next;
         sat_hi_reg    <= hi_next;
         sat_lo_reg    <= lo_next;
         if (bus.op == OP_CLR) begin
            acc_reg        <= '0;
            sat_sticky_reg <= 1'b0;
            sat_cnt_reg    <= '0;
         end else begin
            if (bus.op == OP_ACC) begin
               acc_reg <= res_next;
            end
            // Counter saturates at all-ones instead of wrapping.
            if (hi_next || lo_next) begin
               sat_sticky_reg <= 1'b1;
               if (!(&sat_cnt_reg)) begin
                  sat_cnt_reg <= sat_cnt_reg + {{(CW-1){1'b0}}, 1'b1};
               end
            end
         end
      end else if (bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.out_valid  = out_valid_reg;
   assign bus.SUMA       = suma_reg;
   assign bus.sat_hi     = sat_hi_reg;
   assign bus.sat_lo     = sat_lo_reg;
   assign bus.sat_sticky = sat_sticky_reg;
   assign bus.sat_cnt    = sat_cnt_reg;
endmodule

// File: tb/tb_suma_sat_acc.sv
// Directed bench for suma_sat_acc (N=8, CW=4): expected results are queued at
// acceptance by a small arithmetic model and compared when the DUT presents them.
module tb_suma_sat_acc;
   localparam int N  = 8;
   localparam int CW = 4;

   typedef struct {
      logic [7:0] suma;
      logic       hi;
      logic       lo;
      logic       sticky;
      logic [3:0] cnt;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   m_acc;
   int   m_sticky;
   int   m_cnt;
   exp_t q[$];

   suma_sat_acc_if #(.N(N), .CW(CW)) bus ();

   suma_sat_acc #(.N(N), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_push(input logic [1:0] o, input int a, input int b);
      int   raw;
      exp_t e;
      case (o)
         2'b00:   raw = a + b;
         2'b01:   raw = a - b;
         2'b10:   raw = m_acc + a;
         default: raw = 0;
      endcase
      e.hi = (raw > 127);
      e.lo = (raw < -127);
      if (e.hi) raw = 127;
      else if (e.lo) raw = -127;
      if (o == 2'b11) begin
         m_acc    = 0;
         m_sticky = 0;
         m_cnt    = 0;
      end else begin
         if (o == 2'b10) m_acc = raw;
         if (e.hi || e.lo) begin
            m_sticky = 1;
            if (m_cnt < 15) m_cnt++;
         end
      end
      e.suma   = raw[7:0];
      e.sticky = (m_sticky != 0);
      e.cnt    = m_cnt[3:0];
      q.push_back(e);
   endtask

   // One clock cycle: drive, check the presented result, update the scoreboard.
   task automatic step(input logic v, input logic [1:0] o, input int a, input int b, input logic ordy);
      exp_t e;
      logic accept;
      bus.in_valid  = v;
      bus.op        = o;
      bus.A         = a[7:0];
      bus.B         = b[7:0];
      bus.out_ready = ordy;
      #1;
      accept = v && ((q.size() == 0) || ordy);
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || ordy));
      if (q.size() != 0) begin
         e = q[0];
         chk("suma", 32'(bus.SUMA), 32'(e.suma));
         chk("sat_hi", 32'(bus.sat_hi), 32'(e.hi));
         chk("sat_lo", 32'(bus.sat_lo), 32'(e.lo));
         chk("sat_sticky", 32'(bus.sat_sticky), 32'(e.sticky));
         chk("sat_cnt", 32'(bus.sat_cnt), 32'(e.cnt));
         if (ordy) begin
            $display("txn suma=%0d hi=%0b lo=%0b sticky=%0b cnt=%0d",
                     $signed(bus.SUMA), bus.sat_hi, bus.sat_lo, bus.sat_sticky, bus.sat_cnt);
            void'(q.pop_front());
         end
      end
      if (accept) model_push(o, a, b);
      @(negedge clk);
   endtask

   task automatic chk_reset_state();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_suma", 32'(bus.SUMA), 32'd0);
      chk("rst_sat_hi", 32'(bus.sat_hi), 32'd0);
      chk("rst_sat_lo", 32'(bus.sat_lo), 32'd0);
      chk("rst_sat_sticky", 32'(bus.sat_sticky), 32'd0);
      chk("rst_sat_cnt", 32'(bus.sat_cnt), 32'd0);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      m_acc         = 0;
      m_sticky      = 0;
      m_cnt         = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = 2'b00;
      bus.A         = '0;
      bus.B         = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_reset_state();

      // Clamp boundaries of ADD/SUB including the -2^(N-1) operand.
      step(1'b1, 2'b00, 100, 27, 1'b1);
      step(1'b1, 2'b00, 100, 28, 1'b1);
      step(1'b1, 2'b01, -1, 127, 1'b1);
      step(1'b1, 2'b01, 0, -128, 1'b1);
      step(1'b1, 2'b00, -128, 0, 1'b1);
      step(1'b1, 2'b00, -50, -20, 1'b1);

      // Accumulate sequence bracketed by CLR.
      step(1'b1, 2'b11, 0, 0, 1'b1);
      step(1'b1, 2'b10, 60, 99, 1'b1);
      step(1'b1, 2'b10, 60, 0, 1'b1);
      step(1'b1, 2'b10, 60, 0, 1'b1);
      step(1'b1, 2'b10, -100, 0, 1'b1);
      step(1'b1, 2'b00, 1, 2, 1'b1);
      step(1'b1, 2'b11, 0, 0, 1'b1);
      step(1'b0, 2'b00, 0, 0, 1'b1);
      step(1'b0, 2'b00, 0, 0, 1'b1);

      // Backpressure: result must hold, in_ready low, then drain in order.
      step(1'b1, 2'b00, 10, 1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 20, 2, 1'b0);
      step(1'b1, 2'b00, 20, 2, 1'b1);
      step(1'b1, 2'b00, 30, 3, 1'b1);
      step(1'b1, 2'b01, 40, 4, 1'b1);
      step(1'b0, 2'b00, 0, 0, 1'b1);

      // Saturation counter stops at 2^CW-1.
      for (int i = 0; i < 20; i++) step(1'b1, 2'b00, 127, 127, 1'b1);

      // Reset while a result is pending and a new input is offered.
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.op        = 2'b00;
      bus.A         = 8'd1;
      bus.B         = 8'd1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      q.delete();
      m_acc    = 0;
      m_sticky = 0;
      m_cnt    = 0;
      #1;
      chk_reset_state();
      @(negedge clk);
      step(1'b1, 2'b10, 5, 0, 1'b1);
      step(1'b0, 2'b00, 0, 0, 1'b1);
      step(1'b0, 2'b00, 0, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
